rob: RTL and testbench

- Reorder buffer for the out-of-order rv32i core.
- Sits between decode/issue and the register-rename file. It allocates one tag per issued instruction and captures results from the common data bus (CDB).
- Retires entries in program order, one per cycle.
- Drives the per-entry result array, the per-entry destination-register array and the flush descriptor that the rename file consumes.

---
 rtl/rv32i_types.sv | 32 +++
 rtl/rob_ptr.sv | 38 +++
 rtl/rob.sv | 172 +++++++++++++++++
 tb/tb_rob.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared types for the out-of-order rv32i core: CDB/ROB result slots,
// the flush descriptor consumed by rename, and the ROB entry layout.
package rv32i_types;

    localparam int ROB_TAG_W = 4;
    localparam int XLEN      = 32;

    // One result slot as seen by the rename file
    typedef struct packed {
        logic [ROB_TAG_W-1:0] tag;
        logic [XLEN-1:0]      data;
        logic                 rdy;
    } sal2_t;

    // Flush descriptor: the squashed range and the surviving window
    typedef struct packed {
        logic                 valid;
        logic [ROB_TAG_W-1:0] front_tag;
        logic [ROB_TAG_W-1:0] rear_tag;
        logic [ROB_TAG_W-1:0] flush_tag;
    } flush_t;

    // Bookkeeping for one in-flight instruction
    typedef struct packed {
        logic            valid;
        logic            done;
        logic            is_br;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } rob_entry_t;

endpackage

// File: rtl/rob_ptr.sv
// Wrapping circular-buffer pointer. The width equals log2 of the buffer
// depth, so the increment wraps naturally; load takes priority over inc.
module rob_ptr #(
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             load,
    input  logic [IDX_W-1:0] load_val,
    output logic [IDX_W-1:0] ptr
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;

    // Pick the next pointer value: a load (redirect) overrides a step
    always_comb begin
        ptr_d = ptr_q;
        if (load) begin
            ptr_d = load_val;
        end else if (inc) begin
            ptr_d = ptr_q + IDX_W'(1);
        end
    end

    // Pointer register, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/rob.sv
// Reorder buffer: allocates tags in program order, captures CDB results,
// retires the head entry once it is done, and squashes everything younger
// than a mispredicted branch while reporting the flush to rename.
module rob
    import rv32i_types::*;
#(
    parameter int size  = 8,
    parameter int width = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_valid,
    input  logic [4:0]           alloc_rd,
    input  logic                 alloc_is_br,
    output logic                 alloc_ready,
    output logic [ROB_TAG_W-1:0] alloc_tag,
    input  logic                 wb_valid,
    input  logic [ROB_TAG_W-1:0] wb_tag,
    input  logic [width-1:0]     wb_data,
    input  logic                 wb_mispredict,
    output sal2_t                rdest [size],
    output logic [4:0]           rd_bus [size],
    output logic                 commit_valid,
    output logic [4:0]           commit_rd,
    output logic [width-1:0]     commit_data,
    output logic [ROB_TAG_W-1:0] commit_tag,
    output flush_t               flush,
    output logic                 full,
    output logic                 empty
);

    localparam int IDX_W = $clog2(size);
    localparam int CNT_W = IDX_W + 1;

    rob_entry_t       entries_q [size];
    rob_entry_t       entries_d [size];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    flush_t           flush_q;
    flush_t           flush_d;

    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;
    logic [IDX_W-1:0] wbIdx;
    logic [IDX_W-1:0] relWb;
    logic [IDX_W-1:0] flushIdx;
    logic [IDX_W-1:0] rearIdx;
    logic             wbInRange;
    logic             wbHit;
    logic             flushEvent;
    logic             allocFire;
    logic             commitFire;

    // Tags wider than the buffer index are only valid below size
    assign wbIdx      = wb_tag[IDX_W-1:0];
    assign wbInRange  = ({1'b0, wb_tag} < (ROB_TAG_W + 1)'(size));
    assign wbHit      = wb_valid & wbInRange & entries_q[wbIdx].valid;
    assign flushEvent = wbHit & wb_mispredict & entries_q[wbIdx].is_br;

    // Occupancy flags come from the registered count only
    assign full        = (count_q == CNT_W'(size));
    assign empty       = (count_q == '0);
    assign alloc_ready = ~full;
    assign alloc_tag   = ROB_TAG_W'(tail);
    assign allocFire   = alloc_valid & alloc_ready & ~flushEvent;
    assign commitFire  = entries_q[head].valid & entries_q[head].done;

    // Distances measured from head give program-order age
    assign relWb    = wbIdx - head;
    assign flushIdx = wbIdx + IDX_W'(1);
    assign rearIdx  = tail - IDX_W'(1);

    rob_ptr #(.IDX_W(IDX_W)) u_head (
        .clk      (clk),
        .rst      (rst),
        .inc      (commitFire),
        .load     (1'b0),
        .load_val ('0),
        .ptr      (head)
    );

    rob_ptr #(.IDX_W(IDX_W)) u_tail (
        .clk      (clk),
        .rst      (rst),
        .inc      (allocFire),
        .load     (flushEvent),
        .load_val (flushIdx),
        .ptr      (tail)
    );

    // Next entry state: allocate, capture writeback, squash, then retire
    always_comb begin
        for (int i = 0; i < size; i++) begin
            entries_d[i] = entries_q[i];
            if (allocFire && (IDX_W'(i) == tail)) begin
                entries_d[i].valid = 1'b1;
                entries_d[i].done  = 1'b0;
                entries_d[i].is_br = alloc_is_br;
                entries_d[i].rd    = alloc_rd;
                entries_d[i].data  = '0;
            end
            if (wbHit && (IDX_W'(i) == wbIdx)) begin
                entries_d[i].done = 1'b1;
                entries_d[i].data = XLEN'(wb_data);
            end
            if (flushEvent && ((IDX_W'(i) - head) > relWb)) begin
                entries_d[i].valid = 1'b0;
                entries_d[i].done  = 1'b0;
            end
            if (commitFire && (IDX_W'(i) == head)) begin
                entries_d[i] = '0;
            end
        end
    end

    // Occupancy and flush descriptor for the next cycle
    always_comb begin
        count_d = count_q + CNT_W'(allocFire) - CNT_W'(commitFire);
        flush_d = '0;
        if (flushEvent) begin
            count_d           = CNT_W'(relWb) + CNT_W'(1) - CNT_W'(commitFire);
            flush_d.valid     = 1'b1;
            flush_d.front_tag = ROB_TAG_W'(head);
            flush_d.rear_tag  = ROB_TAG_W'(rearIdx);
            flush_d.flush_tag = ROB_TAG_W'(flushIdx);
        end
    end

    // All ROB state other than the pointers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < size; i++) begin
                entries_q[i] <= '0;
            end
            count_q <= '0;
            flush_q <= '0;
        end else begin
            for (int i = 0; i < size; i++) begin
                entries_q[i] <= entries_d[i];
            end
            count_q <= count_d;
            flush_q <= flush_d;
        end
    end

    assign flush = flush_q;

    // Per-entry views for rename: result slots and destination registers
    always_comb begin
        for (int i = 0; i < size; i++) begin
            rdest[i].tag  = ROB_TAG_W'(i);
            rdest[i].data = entries_q[i].data;
            rdest[i].rdy  = entries_q[i].valid & entries_q[i].done;
            rd_bus[i]     = entries_q[i].valid ? entries_q[i].rd : 5'd0;
        end
    end

    // Retirement port shows the head entry only while it retires
    always_comb begin
        commit_valid = 1'b0;
        commit_rd    = '0;
        commit_data  = '0;
        commit_tag   = '0;
        if (commitFire) begin
            commit_valid = 1'b1;
            commit_rd    = entries_q[head].rd;
            commit_data  = width'(entries_q[head].data);
            commit_tag   = ROB_TAG_W'(head);
        end
    end

endmodule

// File: tb/tb_rob.sv
// Directed self-checking bench for the reorder buffer.
module tb_rob;
    import rv32i_types::*;

    logic        clk;
    logic        rst;
    logic        alloc_valid;
    logic [4:0]  alloc_rd;
    logic        alloc_is_br;
    logic        alloc_ready;
    logic [3:0]  alloc_tag;
    logic        wb_valid;
    logic [3:0]  wb_tag;
    logic [31:0] wb_data;
    logic        wb_mispredict;
    sal2_t       rdest [8];
    logic [4:0]  rd_bus [8];
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [31:0] commit_data;
    logic [3:0]  commit_tag;
    flush_t      flush;
    logic        full;
    logic        empty;

    int testsRun;
    int testsFailed;

    rob #(.size(8), .width(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .alloc_valid   (alloc_valid),
        .alloc_rd      (alloc_rd),
        .alloc_is_br   (alloc_is_br),
        .alloc_ready   (alloc_ready),
        .alloc_tag     (alloc_tag),
        .wb_valid      (wb_valid),
        .wb_tag        (wb_tag),
        .wb_data       (wb_data),
        .wb_mispredict (wb_mispredict),
        .rdest         (rdest),
        .rd_bus        (rd_bus),
        .commit_valid  (commit_valid),
        .commit_rd     (commit_rd),
        .commit_data   (commit_data),
        .commit_tag    (commit_tag),
        .flush         (flush),
        .full          (full),
        .empty         (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic abr,
                                 input logic wv, input logic [3:0] wtag,
                                 input logic [31:0] wdata, input logic wmis);
        alloc_valid   = av;
        alloc_rd      = ard;
        alloc_is_br   = abr;
        wb_valid      = wv;
        wb_tag        = wtag;
        wb_data       = wdata;
        wb_mispredict = wmis;
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst         = 1'b1;
        idle();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;

        // Reset values
        checkOutput("rst_empty", 32'(empty), 1);
        checkOutput("rst_full", 32'(full), 0);
        checkOutput("rst_ready", 32'(alloc_ready), 1);
        checkOutput("rst_tag", 32'(alloc_tag), 0);
        checkOutput("rst_commit", 32'(commit_valid), 0);
        checkOutput("rst_flush", 32'(flush.valid), 0);

        // Reset mid-operation, no clock edge
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 5'(i + 1), 1'b0, 1'b0, 4'd0, 32'd0, 1'b0);
            tick();
        end
        idle();
        checkOutput("mid_tag_pre", 32'(alloc_tag), 3);
        checkOutput("mid_empty_pre", 32'(empty), 0);
        rst = 1'b1;
        #1;
        checkOutput("mid_empty", 32'(empty), 1);
        checkOutput("mid_tag", 32'(alloc_tag), 0);
        checkOutput("mid_rdbus0", 32'(rd_bus[0]), 0);
        rst = 1'b0;
        #1;

        // Fill: eight allocations, then an ignored ninth
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 5'(i + 1), 1'b0, 1'b0, 4'd0, 32'd0, 1'b0);
            checkOutput("fill_tag", 32'(alloc_tag), i);
            tick();
        end
        idle();
        checkOutput("fill_full", 32'(full), 1);
        checkOutput("fill_ready", 32'(alloc_ready), 0);
        applyStimulus(1'b1, 5'd9, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0);
        tick();
        idle();
        checkOutput("ninth_tag", 32'(alloc_tag), 0);
        checkOutput("ninth_rd0", 32'(rd_bus[0]), 1);
        checkOutput("ninth_full", 32'(full), 1);

        // Retire in order on consecutive cycles
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 4'(i), 32'(100 + i), 1'b0);
            checkOutput("wb_rdy_before", 32'(rdest[i].rdy), 0);
            if (i > 0) begin
                checkOutput("ret_valid", 32'(commit_valid), 1);
                checkOutput("ret_tag", 32'(commit_tag), i - 1);
                checkOutput("ret_data", commit_data, 100 + i - 1);
                checkOutput("ret_rd", 32'(commit_rd), i);
            end else begin
                checkOutput("ret_none", 32'(commit_valid), 0);
            end
            tick();
            checkOutput("wb_rdy_after", 32'(rdest[i].rdy), 1);
        end
        idle();
        checkOutput("ret_last_tag", 32'(commit_tag), 7);
        checkOutput("ret_last_data", commit_data, 107);
        checkOutput("ret_last_rd", 32'(commit_rd), 8);
        tick();
        checkOutput("ret_empty", 32'(empty), 1);
        checkOutput("ret_novalid", 32'(commit_valid), 0);

        // Out-of-order writeback
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 5'(10 + i), 1'b0, 1'b0, 4'd0, 32'd0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 4'd2, 32'h22, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 4'd0, 32'h20, 1'b0);
        checkOutput("ooo_no_commit", 32'(commit_valid), 0);
        tick();
        idle();
        checkOutput("ooo_c0_valid", 32'(commit_valid), 1);
        checkOutput("ooo_c0_tag", 32'(commit_tag), 0);
        checkOutput("ooo_c0_data", commit_data, 32'h20);
        checkOutput("ooo_t2_rdy", 32'(rdest[2].rdy), 1);
        tick();
        checkOutput("ooo_blocked", 32'(commit_valid), 0);
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 4'd1, 32'h21, 1'b0);
        tick();
        idle();
        checkOutput("ooo_c1_tag", 32'(commit_tag), 1);
        checkOutput("ooo_c1_data", commit_data, 32'h21);
        tick();
        checkOutput("ooo_c2_valid", 32'(commit_valid), 1);
        checkOutput("ooo_c2_tag", 32'(commit_tag), 2);
        checkOutput("ooo_c2_data", commit_data, 32'h22);
        checkOutput("ooo_c2_rd", 32'(commit_rd), 12);
        tick();
        checkOutput("ooo_empty", 32'(empty), 1);

        // Mispredict with head at 0
        doReset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 5'(i + 1), (i == 2), 1'b0, 4'd0, 32'd0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 4'd2, 32'h55, 1'b1);
        checkOutput("mp_flush_pre", 32'(flush.valid), 0);
        tick();
        idle();
        checkOutput("mp_flush_valid", 32'(flush.valid), 1);
        checkOutput("mp_front", 32'(flush.front_tag), 0);
        checkOutput("mp_rear", 32'(flush.rear_tag), 5);
        checkOutput("mp_flush_tag", 32'(flush.flush_tag), 3);
        checkOutput("mp_alloc_tag", 32'(alloc_tag), 3);
        for (int i = 3; i < 6; i++) begin
            checkOutput("mp_squashed_rd", 32'(rd_bus[i]), 0);
        end
        checkOutput("mp_branch_rd", 32'(rd_bus[2]), 3);
        checkOutput("mp_branch_rdy", 32'(rdest[2].rdy), 1);
        checkOutput("mp_branch_data", rdest[2].data, 32'h55);
        tick();
        checkOutput("mp_flush_pulse", 32'(flush.valid), 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 5'd20, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0);
            tick();
            checkOutput("mp_count_full", 32'(full), (i == 4));
        end
        idle();

        // Wrap-around mispredict with head at 6
        doReset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 5'd1, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0);
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 4'(i), 32'(i), 1'b0);
            tick();
        end
        idle();
        tick();
        checkOutput("wrap_empty", 32'(empty), 1);
        checkOutput("wrap_tag6", 32'(alloc_tag), 6);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 5'(16 + i), (i == 1), 1'b0, 4'd0, 32'd0, 1'b0);
            checkOutput("wrap_alloc_tag", 32'(alloc_tag), (6 + i) % 8);
            tick();
        end
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 4'd7, 32'h77, 1'b1);
        tick();
        idle();
        checkOutput("wrap_flush_valid", 32'(flush.valid), 1);
        checkOutput("wrap_front", 32'(flush.front_tag), 6);
        checkOutput("wrap_rear", 32'(flush.rear_tag), 1);
        checkOutput("wrap_flush_tag", 32'(flush.flush_tag), 0);
        checkOutput("wrap_alloc_tag0", 32'(alloc_tag), 0);
        checkOutput("wrap_rd0", 32'(rd_bus[0]), 0);
        checkOutput("wrap_rd1", 32'(rd_bus[1]), 0);
        checkOutput("wrap_rd7", 32'(rd_bus[7]), 17);

        // Branch is already the youngest: nothing squashed, still pulses
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 4'd7, 32'h78, 1'b1);
        tick();
        idle();
        checkOutput("young_flush_valid", 32'(flush.valid), 1);
        checkOutput("young_flush_tag", 32'(flush.flush_tag), 0);
        checkOutput("young_rear", 32'(flush.rear_tag), 7);
        checkOutput("young_alloc_tag", 32'(alloc_tag), 0);
        checkOutput("young_rd6", 32'(rd_bus[6]), 16);
        tick();
        checkOutput("young_pulse", 32'(flush.valid), 0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 5'd21, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0);
            tick();
            checkOutput("wrap_count_full", 32'(full), (i == 5));
        end
        idle();

        // Commit, alloc and mispredict in the same cycle
        doReset();
        applyStimulus(1'b1, 5'd1, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0);
        tick();
        applyStimulus(1'b1, 5'd2, 1'b1, 1'b0, 4'd0, 32'd0, 1'b0);
        tick();
        applyStimulus(1'b1, 5'd3, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b1, 4'd0, 32'h70, 1'b0);
        tick();
        applyStimulus(1'b1, 5'd4, 1'b0, 1'b1, 4'd1, 32'h71, 1'b1);
        checkOutput("sim_commit_valid", 32'(commit_valid), 1);
        checkOutput("sim_commit_tag", 32'(commit_tag), 0);
        checkOutput("sim_commit_data", commit_data, 32'h70);
        checkOutput("sim_alloc_tag_pre", 32'(alloc_tag), 3);
        tick();
        idle();
        checkOutput("sim_flush_valid", 32'(flush.valid), 1);
        checkOutput("sim_front", 32'(flush.front_tag), 0);
        checkOutput("sim_rear", 32'(flush.rear_tag), 2);
        checkOutput("sim_flush_tag", 32'(flush.flush_tag), 2);
        checkOutput("sim_alloc_tag", 32'(alloc_tag), 2);
        checkOutput("sim_dropped_rd3", 32'(rd_bus[3]), 0);
        checkOutput("sim_squashed_rd2", 32'(rd_bus[2]), 0);
        checkOutput("sim_retired_rd0", 32'(rd_bus[0]), 0);
        checkOutput("sim_br_commit", 32'(commit_valid), 1);
        checkOutput("sim_br_tag", 32'(commit_tag), 1);
        checkOutput("sim_br_data", commit_data, 32'h71);
        tick();
        checkOutput("sim_empty", 32'(empty), 1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
